spi_dcs_sink: RTL and testbench



---
 rtl/spi_dcs_sink_pkg.sv | 18 +
 rtl/spi_dcs_sink_byte_rx.sv | 55 +++++
 rtl/spi_dcs_sink.sv | 152 +++++++++++++++
 tb/tb_spi_dcs_sink.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dcs_sink_pkg.sv
// Shared DCS opcodes and parser state encoding for the SPI display sink.
package spi_dcs_sink_pkg;

    localparam logic [7:0] DCS_NOP     = 8'h00;
    localparam logic [7:0] DCS_SWRESET = 8'h01;
    localparam logic [7:0] DCS_CASET   = 8'h2A;
    localparam logic [7:0] DCS_PASET   = 8'h2B;
    localparam logic [7:0] DCS_RAMWR   = 8'h2C;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CASET = 3'd1,
        PASET = 3'd2,
        RAMWR = 3'd3,
        SKIP  = 3'd4
    } parser_state_t;

endpackage

// File: rtl/spi_dcs_sink_byte_rx.sv
// Oversampling SPI mode-0 byte receiver: synchronisers, edge detect, bit counter, shifter.
module spi_byte_rx #(
    parameter int SYNC = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       spi_cs_n,
    input  logic       spi_clock,
    input  logic       spi_dc,
    input  logic       spi_mosi,
    output logic       byte_valid,
    output logic       byte_dc,
    output logic [7:0] rx_byte,
    output logic       cs_idle
);

    logic [SYNC-1:0] cs_sync, sclk_sync, dc_sync, mosi_sync;
    logic            sclk_q;
    logic [2:0]      bit_cnt;
    logic [6:0]      shift;
    logic            sclk_rise;

    // Chip select synchroniser resets to the deselected level.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            dc_sync   <= '0;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            bit_cnt   <= 3'd0;
            shift     <= 7'd0;
        end else begin
            cs_sync   <= {cs_sync[SYNC-2:0], spi_cs_n};
            sclk_sync <= {sclk_sync[SYNC-2:0], spi_clock};
            dc_sync   <= {dc_sync[SYNC-2:0], spi_dc};
            mosi_sync <= {mosi_sync[SYNC-2:0], spi_mosi};
            sclk_q    <= sclk_sync[SYNC-1];
            if (cs_idle) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                shift   <= {shift[5:0], mosi_sync[SYNC-1]};
            end
        end
    end

    assign cs_idle    = cs_sync[SYNC-1];
    assign sclk_rise  = sclk_sync[SYNC-1] & ~sclk_q & ~cs_sync[SYNC-1];
    // Completing byte is presented combinationally on the 8th edge.
    assign byte_valid = sclk_rise & (bit_cnt == 3'd7);
    assign rx_byte    = {shift, mosi_sync[SYNC-1]};
    assign byte_dc    = dc_sync[SYNC-1];

endmodule

// File: rtl/spi_dcs_sink.sv
// DCS command parser: window registers, write cursor and RGB565 pixel assembly.
module spi_dcs_sink
    import spi_dcs_sink_pkg::*;
#(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320,
    parameter int SYNC   = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        spi_cs_n,
    input  logic        spi_clock,
    input  logic        spi_dc,
    input  logic        spi_mosi,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code,
    output logic        px_valid,
    output logic [15:0] px_x,
    output logic [15:0] px_y,
    output logic [15:0] px_data
);

    localparam logic [15:0] X_END_RST = 16'(WIDTH - 1);
    localparam logic [15:0] Y_END_RST = 16'(HEIGHT - 1);

    // Outputs are valid-only strobes with no back-pressure: cmd_valid/px_valid
    // pulse for one cycle, and their payloads hold until the next pulse.
    logic          byte_valid, byte_dc, cs_idle;
    logic [7:0]    rx_byte;
    logic          is_cmd, is_data;
    parser_state_t state, state_d;
    logic [1:0]    arg_idx;
    logic [23:0]   arg_sr;
    logic [15:0]   x_start, x_end, y_start, y_end;
    logic [15:0]   cur_x, cur_y;
    logic          half;
    logic [7:0]    hi_byte;

    spi_byte_rx #(.SYNC(SYNC)) u_rx (
        .clock      (clock),
        .reset_n    (reset_n),
        .spi_cs_n   (spi_cs_n),
        .spi_clock  (spi_clock),
        .spi_dc     (spi_dc),
        .spi_mosi   (spi_mosi),
        .byte_valid (byte_valid),
        .byte_dc    (byte_dc),
        .rx_byte    (rx_byte),
        .cs_idle    (cs_idle)
    );

    assign is_cmd  = byte_valid & ~byte_dc;
    assign is_data = byte_valid & byte_dc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (is_cmd) begin
            case (rx_byte)
                DCS_CASET: state_d = CASET;
                DCS_PASET: state_d = PASET;
                DCS_RAMWR: state_d = RAMWR;
                default:   state_d = SKIP;
            endcase
        end else if (is_data && (state == CASET || state == PASET) && arg_idx == 2'd3) begin
            state_d = SKIP;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 8'd0;
            px_valid  <= 1'b0;
            px_x      <= 16'd0;
            px_y      <= 16'd0;
            px_data   <= 16'd0;
            arg_idx   <= 2'd0;
            arg_sr    <= 24'd0;
            x_start   <= 16'd0;
            y_start   <= 16'd0;
            x_end     <= X_END_RST;
            y_end     <= Y_END_RST;
            cur_x     <= 16'd0;
            cur_y     <= 16'd0;
            half      <= 1'b0;
            hi_byte   <= 8'd0;
        end else begin
            cmd_valid <= 1'b0;
            px_valid  <= 1'b0;
            if (cs_idle) half <= 1'b0;
            if (is_cmd) begin
                cmd_valid <= 1'b1;
                cmd_code  <= rx_byte;
                arg_idx   <= 2'd0;
                half      <= 1'b0;
                if (rx_byte == DCS_RAMWR) begin
                    cur_x <= x_start;
                    cur_y <= y_start;
                end
                if (rx_byte == DCS_SWRESET) begin
                    x_start <= 16'd0;
                    y_start <= 16'd0;
                    x_end   <= X_END_RST;
                    y_end   <= Y_END_RST;
                end
            end else if (is_data) begin
                case (state)
                    CASET, PASET: begin
                        arg_idx <= arg_idx + 2'd1;
                        arg_sr  <= {arg_sr[15:0], rx_byte};
                        // Fourth argument commits start/end together.
                        if (arg_idx == 2'd3) begin
                            if (state == CASET) begin
                                x_start <= arg_sr[23:8];
                                x_end   <= {arg_sr[7:0], rx_byte};
                            end else begin
                                y_start <= arg_sr[23:8];
                                y_end   <= {arg_sr[7:0], rx_byte};
                            end
                        end
                    end
                    RAMWR: begin
                        if (!half) begin
                            hi_byte <= rx_byte;
                            half    <= 1'b1;
                        end else begin
                            px_valid <= 1'b1;
                            px_x     <= cur_x;
                            px_y     <= cur_y;
                            px_data  <= {hi_byte, rx_byte};
                            half     <= 1'b0;
                            // Inverted windows wrap through 0xFFFF by design.
                            if (cur_x == x_end) begin
                                cur_x <= x_start;
                                cur_y <= (cur_y == y_end) ? y_start : cur_y + 16'd1;
                            end else begin
                                cur_x <= cur_x + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_dcs_sink.sv
// Directed bench for spi_dcs_sink with a DCS-level reference model and scoreboard.
module tb_spi_dcs_sink;

    localparam int HP = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        spi_cs_n = 1'b1;
    logic        spi_clock = 1'b0;
    logic        spi_dc = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        cmd_valid, px_valid;
    logic [7:0]  cmd_code;
    logic [15:0] px_x, px_y, px_data;

    always #5 clock = ~clock;

    spi_dcs_sink dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .spi_cs_n  (spi_cs_n),
        .spi_clock (spi_clock),
        .spi_dc    (spi_dc),
        .spi_mosi  (spi_mosi),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .px_valid  (px_valid),
        .px_x      (px_x),
        .px_y      (px_y),
        .px_data   (px_data)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  exp_cmd_q[$];
    logic [7:0]  obs_cmd_q[$];
    logic [47:0] exp_px_q[$];
    logic [47:0] obs_px_q[$];

    // Reference model state (DCS semantics only)
    int          m_mode;   // 0 idle, 1 column args, 2 row args, 3 memory write, 4 skip
    logic [7:0]  m_args[4];
    int          m_nargs;
    logic [15:0] mxs, mxe, mys, mye, mcx, mcy;
    bit          m_half;
    logic [7:0]  m_hi;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_nargs = 0; m_half = 0; m_hi = 8'd0;
        mxs = 16'd0; mys = 16'd0; mxe = 16'd239; mye = 16'd319;
        mcx = 16'd0; mcy = 16'd0;
    endtask

    task automatic model_byte(input bit dc, input logic [7:0] b);
        if (!dc) begin
            exp_cmd_q.push_back(b);
            m_half = 0; m_nargs = 0;
            if (b == 8'h2A)      m_mode = 1;
            else if (b == 8'h2B) m_mode = 2;
            else if (b == 8'h2C) begin m_mode = 3; mcx = mxs; mcy = mys; end
            else begin
                if (b == 8'h01) begin mxs = 0; mys = 0; mxe = 16'd239; mye = 16'd319; end
                m_mode = 4;
            end
        end else if (m_mode == 1 || m_mode == 2) begin
            m_args[m_nargs] = b;
            m_nargs++;
            if (m_nargs == 4) begin
                if (m_mode == 1) begin mxs = {m_args[0], m_args[1]}; mxe = {m_args[2], m_args[3]}; end
                else             begin mys = {m_args[0], m_args[1]}; mye = {m_args[2], m_args[3]}; end
                m_mode = 4;
            end
        end else if (m_mode == 3) begin
            if (!m_half) begin
                m_hi = b; m_half = 1;
            end else begin
                exp_px_q.push_back({mcx, mcy, m_hi, b});
                m_half = 0;
                if (mcx == mxe) begin
                    mcx = mxs;
                    mcy = (mcy == mye) ? mys : mcy + 16'd1;
                end else begin
                    mcx = mcx + 16'd1;
                end
            end
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bits(input bit dc, input logic [7:0] b, input int n);
        spi_cs_n = 1'b0;
        spi_dc   = dc;
        for (int i = 0; i < n; i++) begin
            spi_clock = 1'b0;
            spi_mosi  = b[7-i];
            wait_clk(HP);
            spi_clock = 1'b1;
            wait_clk(HP);
        end
        spi_clock = 1'b0;
    endtask

    task automatic send_byte(input bit dc, input logic [7:0] b);
        model_byte(dc, b);
        send_bits(dc, b, 8);
    endtask

    task automatic cs_high();
        spi_clock = 1'b0;
        spi_cs_n  = 1'b1;
        m_half    = 0;
        wait_clk(HP + 2);
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clk(HP + 2);
    endtask

    task automatic clear_obs();
        obs_cmd_q.delete();
        obs_px_q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_cmd_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_cmd_code"},  64'(cmd_code),  64'd0);
        check({tag, "_px_valid"},  64'(px_valid),  64'd0);
        check({tag, "_px_x"},      64'(px_x),      64'd0);
        check({tag, "_px_y"},      64'(px_y),      64'd0);
        check({tag, "_px_data"},   64'(px_data),   64'd0);
    endtask

    // Scoreboard: every strobe must match the model's next expected item.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (cmd_valid === 1'b1) begin
                obs_cmd_q.push_back(cmd_code);
                if (exp_cmd_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL cmd_unexpected: got %0h expected none", cmd_code);
                end else begin
                    check("cmd_code", 64'(cmd_code), 64'(exp_cmd_q.pop_front()));
                end
            end
            if (px_valid === 1'b1) begin
                obs_px_q.push_back({px_x, px_y, px_data});
                if (exp_px_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL px_unexpected: got %0h expected none", {px_x, px_y, px_data});
                end else begin
                    check("px", 64'({px_x, px_y, px_data}), 64'(exp_px_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] lx[5];
        logic [15:0] ly[5];
        logic [15:0] k;
        lx = '{16'd16, 16'd17, 16'd16, 16'd17, 16'd16};
        ly = '{16'd32, 16'd32, 16'd33, 16'd33, 16'd32};

        // Reset state
        reset_n = 1'b0;
        model_reset();
        wait_clk(3);
        check_zero_outputs("rst");
        reset_n = 1'b1;
        wait_clk(3);

        // Column/row window then a 2x2 fill with wrap
        clear_obs();
        cs_low();
        send_byte(0, 8'h2A);
        send_byte(1, 8'h00); send_byte(1, 8'h10); send_byte(1, 8'h00); send_byte(1, 8'h11);
        send_byte(0, 8'h2B);
        send_byte(1, 8'h00); send_byte(1, 8'h20); send_byte(1, 8'h00); send_byte(1, 8'h21);
        send_byte(0, 8'h2C);
        for (int i = 1; i <= 5; i++) begin
            send_byte(1, 8'hA0);
            send_byte(1, 8'(i));
        end
        wait_clk(20);
        check("win_px_count", 64'(obs_px_q.size()), 64'd5);
        for (int i = 0; i < 5; i++)
            check("win_px_lit", 64'(obs_px_q[i]), 64'({lx[i], ly[i], 16'hA000 + 16'(i + 1)}));
        check("win_cmd_count", 64'(obs_cmd_q.size()), 64'd3);
        check("win_cmd0", 64'(obs_cmd_q[0]), 64'h2A);
        check("win_cmd1", 64'(obs_cmd_q[1]), 64'h2B);
        check("win_cmd2", 64'(obs_cmd_q[2]), 64'h2C);

        // Reset mid-byte clears held outputs immediately
        check("pre_rst_exp_px_empty", 64'(exp_px_q.size()), 64'd0);
        send_bits(1, 8'hFF, 3);
        reset_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        spi_cs_n  = 1'b1;
        spi_clock = 1'b0;
        exp_cmd_q.delete();
        exp_px_q.delete();
        model_reset();
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(2);
        clear_obs();
        cs_low();
        send_byte(0, 8'h2C);
        send_byte(1, 8'hF8); send_byte(1, 8'h00);
        wait_clk(20);
        check("post_rst_px_count", 64'(obs_px_q.size()), 64'd1);
        check("post_rst_px", 64'(obs_px_q[0]), 64'({16'd0, 16'd0, 16'hF800}));

        // Fragment dropped on chip-select release
        clear_obs();
        send_bits(0, 8'h2C, 5);
        cs_high();
        cs_low();
        send_byte(0, 8'h2C);
        wait_clk(20);
        check("frag_cmd_count", 64'(obs_cmd_q.size()), 64'd1);
        check("frag_cmd", 64'(obs_cmd_q[0]), 64'h2C);

        // Incomplete column window discarded
        clear_obs();
        send_byte(0, 8'h2A);
        send_byte(1, 8'h00); send_byte(1, 8'h05);
        send_byte(0, 8'h2C);
        send_byte(1, 8'hF0); send_byte(1, 8'h0F);
        wait_clk(20);
        check("short_px_count", 64'(obs_px_q.size()), 64'd1);
        check("short_px", 64'(obs_px_q[0]), 64'({16'd0, 16'd0, 16'hF00F}));

        // Pending high byte dropped on chip-select release
        clear_obs();
        send_byte(0, 8'h2C);
        send_byte(1, 8'hAB);
        cs_high();
        cs_low();
        send_byte(1, 8'h12); send_byte(1, 8'h34);
        wait_clk(20);
        check("half_px_count", 64'(obs_px_q.size()), 64'd1);
        check("half_px", 64'(obs_px_q[0]), 64'({16'd0, 16'd0, 16'h1234}));

        // Unknown opcode with data, then SWRESET restores the full window
        clear_obs();
        send_byte(0, 8'h36);
        send_byte(1, 8'h48);
        send_byte(0, 8'h2A);
        send_byte(1, 8'h00); send_byte(1, 8'h10); send_byte(1, 8'h00); send_byte(1, 8'h11);
        send_byte(0, 8'h01);
        wait_clk(20);
        check("swr_no_px", 64'(obs_px_q.size()), 64'd0);
        send_byte(0, 8'h2C);
        for (int i = 0; i <= 240; i++) begin
            k = 16'(i);
            send_byte(1, k[15:8]);
            send_byte(1, k[7:0]);
        end
        wait_clk(20);
        check("swr_cmd_count", 64'(obs_cmd_q.size()), 64'd4);
        check("swr_cmd0", 64'(obs_cmd_q[0]), 64'h36);
        check("swr_cmd2", 64'(obs_cmd_q[2]), 64'h01);
        check("swr_px_count", 64'(obs_px_q.size()), 64'd241);
        check("swr_px_first", 64'(obs_px_q[0]),   64'({16'd0,   16'd0, 16'd0}));
        check("swr_px_xend",  64'(obs_px_q[239]), 64'({16'd239, 16'd0, 16'd239}));
        check("swr_px_wrap",  64'(obs_px_q[240]), 64'({16'd0,   16'd1, 16'd240}));

        cs_high();
        check("end_exp_cmd_empty", 64'(exp_cmd_q.size()), 64'd0);
        check("end_exp_px_empty",  64'(exp_px_q.size()),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
